multicycle_ctrl: RTL and testbench

Parametrised multicycle control unit for the RISC-V datapath, successor of the fixed reset/add/wait sequencer. It walks each instruction through fetch, decode, execute, memory and writeback states. It drives the datapath write enables, mux selects and ALU operation. Memory latency and reset-hold length are configurable, and unsupported encodings trap.

---
 rtl/multicycle_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit for the RISC-V datapath: fetch/decode/execute/memory/writeback
// sequencing with configurable memory wait states, reset hold length and an illegal-encoding trap.
module multicycle_ctrl #(
  parameter int unsigned ALUOP_W      = 3,
  parameter int unsigned MEM_WAIT     = 1,
  parameter int unsigned RESET_CYCLES = 1
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               funct7_5,
  input  logic               zero,
  output logic               reset_wire,
  output logic               pc_write,
  output logic               pc_src,
  output logic               ir_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] operacao,
  output logic               illegal
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_LD  = CNT_W'(MEM_WAIT);
  localparam logic [CNT_W-1:0] RST_HOLD = CNT_W'(RESET_CYCLES);

  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_SD = 7'b0100011;
  localparam logic [6:0] OPC_BR = 7'b1100011;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;

  localparam logic [1:0] SRC_B_REG = 2'b00;
  localparam logic [1:0] SRC_B_4   = 2'b01;
  localparam logic [1:0] SRC_B_IMM = 2'b10;

  typedef enum logic [3:0] {
    ST_RESET, ST_FETCH, ST_DECODE, ST_EXEC_R, ST_EXEC_I, ST_ADDR,
    ST_MEM_RD, ST_MEM_WR, ST_WB_ALU, ST_WB_MEM, ST_BRANCH, ST_TRAP
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  logic [2:0]         w_r_op;
  logic               w_r_legal;

  logic               r_reset_wire, w_reset_wire;
  logic               r_pc_write,   w_pc_write;
  logic               r_pc_src,     w_pc_src;
  logic               r_ir_write,   w_ir_write;
  logic               r_mem_read,   w_mem_read;
  logic               r_mem_write,  w_mem_write;
  logic               r_reg_write,  w_reg_write;
  logic               r_mem_to_reg, w_mem_to_reg;
  logic               r_alu_src_a,  w_alu_src_a;
  logic [1:0]         r_alu_src_b,  w_alu_src_b;
  logic [ALUOP_W-1:0] r_operacao,   w_operacao;
  logic               r_illegal,    w_illegal;
  logic               r_branch,     w_branch;
  logic               r_bne,        w_bne;

  // R-type funct decode; funct7_5 only distinguishes add from sub
  always_comb begin
    w_r_op    = OP_NONE;
    w_r_legal = 1'b1;
    case (funct3)
      3'b000:  w_r_op = funct7_5 ? OP_SUB : OP_ADD;
      3'b111:  w_r_op = OP_AND;
      3'b110:  w_r_op = OP_OR;
      3'b100:  w_r_op = OP_XOR;
      default: w_r_legal = 1'b0;
    endcase
  end

  // Next state and shared wait counter (RESET counts up, memory states count down)
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_RESET: begin
        if (r_cnt >= RST_HOLD) begin
          w_state_nxt = ST_FETCH;
          w_cnt_nxt   = WAIT_LD;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_FETCH: begin
        if (r_cnt == '0) w_state_nxt = ST_DECODE;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      ST_DECODE: begin
        w_state_nxt = ST_TRAP;
        if (opcode == OPC_R && w_r_legal)                                 w_state_nxt = ST_EXEC_R;
        else if (opcode == OPC_I && funct3 == 3'b000)                     w_state_nxt = ST_EXEC_I;
        else if ((opcode == OPC_LD || opcode == OPC_SD) && funct3 == 3'b011) w_state_nxt = ST_ADDR;
        else if (opcode == OPC_BR && funct3[2:1] == 2'b00)                w_state_nxt = ST_BRANCH;
      end
      ST_EXEC_R, ST_EXEC_I: w_state_nxt = ST_WB_ALU;
      ST_ADDR: begin
        w_state_nxt = (opcode == OPC_LD) ? ST_MEM_RD : ST_MEM_WR;
        w_cnt_nxt   = WAIT_LD;
      end
      ST_MEM_RD: begin
        if (r_cnt == '0) w_state_nxt = ST_WB_MEM;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      ST_MEM_WR: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_FETCH;
          w_cnt_nxt   = WAIT_LD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_WB_ALU, ST_WB_MEM, ST_BRANCH: begin
        w_state_nxt = ST_FETCH;
        w_cnt_nxt   = WAIT_LD;
      end
      ST_TRAP: w_state_nxt = ST_TRAP;
      default: w_state_nxt = ST_TRAP;
    endcase
  end

  // Outputs decoded from the state being entered so the registers present Moore values
  always_comb begin
    w_reset_wire = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_src     = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = SRC_B_REG;
    w_operacao   = ALUOP_W'(OP_NONE);
    w_illegal    = 1'b0;
    w_branch     = 1'b0;
    w_bne        = 1'b0;
    case (w_state_nxt)
      ST_RESET: w_reset_wire = 1'b1;
      ST_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = SRC_B_4;
        w_operacao  = ALUOP_W'(OP_ADD);
        if (w_cnt_nxt == '0) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
        end
      end
      ST_DECODE: begin
        w_alu_src_b = SRC_B_IMM;
        w_operacao  = ALUOP_W'(OP_ADD);
      end
      ST_EXEC_R: begin
        w_alu_src_a = 1'b1;
        w_operacao  = ALUOP_W'(w_r_op);
      end
      ST_EXEC_I, ST_ADDR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRC_B_IMM;
        w_operacao  = ALUOP_W'(OP_ADD);
      end
      ST_MEM_RD: w_mem_read  = 1'b1;
      ST_MEM_WR: w_mem_write = 1'b1;
      ST_WB_ALU: w_reg_write = 1'b1;
      ST_WB_MEM: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
      end
      ST_BRANCH: begin
        w_alu_src_a = 1'b1;
        w_pc_src    = 1'b1;
        w_operacao  = ALUOP_W'(OP_SUB);
        w_branch    = 1'b1;
        w_bne       = funct3[0];
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // State, counter and output registers; reset forces the RESET-state outputs immediately
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= ST_RESET;
      r_cnt        <= '0;
      r_reset_wire <= 1'b1;
      r_pc_write   <= 1'b0;
      r_pc_src     <= 1'b0;
      r_ir_write   <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_alu_src_a  <= 1'b0;
      r_alu_src_b  <= SRC_B_REG;
      r_operacao   <= '0;
      r_illegal    <= 1'b0;
      r_branch     <= 1'b0;
      r_bne        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_reset_wire <= w_reset_wire;
      r_pc_write   <= w_pc_write;
      r_pc_src     <= w_pc_src;
      r_ir_write   <= w_ir_write;
      r_mem_read   <= w_mem_read;
      r_mem_write  <= w_mem_write;
      r_reg_write  <= w_reg_write;
      r_mem_to_reg <= w_mem_to_reg;
      r_alu_src_a  <= w_alu_src_a;
      r_alu_src_b  <= w_alu_src_b;
      r_operacao   <= w_operacao;
      r_illegal    <= w_illegal;
      r_branch     <= w_branch;
      r_bne        <= w_bne;
    end
  end

  // Branch PC load follows the live zero flag; the fetch PC load is purely registered
  assign pc_write   = r_pc_write | (r_branch & (zero ^ r_bne));
  assign reset_wire = r_reset_wire;
  assign pc_src     = r_pc_src;
  assign ir_write   = r_ir_write;
  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;
  assign reg_write  = r_reg_write;
  assign mem_to_reg = r_mem_to_reg;
  assign alu_src_a  = r_alu_src_a;
  assign alu_src_b  = r_alu_src_b;
  assign operacao   = r_operacao;
  assign illegal    = r_illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: two instances (MEM_WAIT=0 and MEM_WAIT=2) driven by directed and random
// instruction streams, checked every cycle against a phase-list model of each instruction.
module tb_multicycle_ctrl;

  localparam int P_RESET = 0, P_FETCH = 1, P_FLAST = 2, P_DECODE = 3, P_EXR = 4, P_EXI = 5;
  localparam int P_MEMRD = 6, P_MEMWR = 7, P_WBA = 8, P_WBM = 9, P_BR = 10, P_TRAP = 11;

  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_SD = 7'b0100011;
  localparam logic [6:0] OPC_BR = 7'b1100011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic [6:0]  opc   [2];
  logic [2:0]  f3    [2];
  logic        f75   [2];
  logic        zr    [2];
  logic [15:0] act   [2];

  logic        o_rw [2], o_pw [2], o_ps [2], o_iw [2], o_mr [2], o_mw [2];
  logic        o_rg [2], o_m2r [2], o_a [2], o_ill [2];
  logic [1:0]  o_b  [2];
  logic [2:0]  op0;
  logic [3:0]  op1;

  int n_cmp  = 0;
  int n_fail = 0;

  multicycle_ctrl #(.ALUOP_W(3), .MEM_WAIT(0), .RESET_CYCLES(1)) u_w0 (
    .CLK(clk), .RST_N(rst_n[0]), .opcode(opc[0]), .funct3(f3[0]), .funct7_5(f75[0]), .zero(zr[0]),
    .reset_wire(o_rw[0]), .pc_write(o_pw[0]), .pc_src(o_ps[0]), .ir_write(o_iw[0]),
    .mem_read(o_mr[0]), .mem_write(o_mw[0]), .reg_write(o_rg[0]), .mem_to_reg(o_m2r[0]),
    .alu_src_a(o_a[0]), .alu_src_b(o_b[0]), .operacao(op0), .illegal(o_ill[0]));

  multicycle_ctrl #(.ALUOP_W(4), .MEM_WAIT(2), .RESET_CYCLES(2)) u_w2 (
    .CLK(clk), .RST_N(rst_n[1]), .opcode(opc[1]), .funct3(f3[1]), .funct7_5(f75[1]), .zero(zr[1]),
    .reset_wire(o_rw[1]), .pc_write(o_pw[1]), .pc_src(o_ps[1]), .ir_write(o_iw[1]),
    .mem_read(o_mr[1]), .mem_write(o_mw[1]), .reg_write(o_rg[1]), .mem_to_reg(o_m2r[1]),
    .alu_src_a(o_a[1]), .alu_src_b(o_b[1]), .operacao(op1), .illegal(o_ill[1]));

  assign act[0] = {o_rw[0], o_pw[0], o_ps[0], o_iw[0], o_mr[0], o_mw[0], o_rg[0], o_m2r[0],
                   o_a[0], o_b[0], {1'b0, op0}, o_ill[0]};
  assign act[1] = {o_rw[1], o_pw[1], o_ps[1], o_iw[1], o_mr[1], o_mw[1], o_rg[1], o_m2r[1],
                   o_a[1], o_b[1], op1, o_ill[1]};

  function automatic int wpar(input int k);
    return (k == 0) ? 0 : 2;
  endfunction

  function automatic int rcyc(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  // R-type ALU op by the encoding table; -1 marks an illegal combination
  function automatic int rop(input logic [2:0] f, input logic f7);
    case (f)
      3'b000:  return f7 ? 2 : 1;
      3'b111:  return 3;
      3'b110:  return 4;
      3'b100:  return 5;
      default: return -1;
    endcase
  endfunction

  function automatic string pname(input int ph);
    case (ph)
      P_RESET: return "reset";   P_FETCH: return "fetch";   P_FLAST: return "fetch_last";
      P_DECODE: return "decode"; P_EXR: return "exec_r";    P_EXI: return "exec_i_addr";
      P_MEMRD: return "mem_rd";  P_MEMWR: return "mem_wr";  P_WBA: return "wb_alu";
      P_WBM: return "wb_mem";    P_BR: return "branch";     default: return "trap";
    endcase
  endfunction

  // Expected output word {rw,pw,ps,iw,mr,mw,rg,m2r,a,b[1:0],op[3:0],ill} for one cycle of a phase
  function automatic logic [15:0] exp_vec(input int ph, input logic [2:0] f, input logic f7,
                                          input logic z);
    logic rw = 0, pw = 0, ps = 0, iw = 0, mr = 0, mw = 0, rg = 0, m2r = 0, a = 0, ill = 0;
    logic [1:0] b = 2'b00;
    int op = 0;
    case (ph)
      P_RESET:  rw = 1;
      P_FETCH:  begin mr = 1; b = 2'b01; op = 1; end
      P_FLAST:  begin mr = 1; b = 2'b01; op = 1; iw = 1; pw = 1; end
      P_DECODE: begin b = 2'b10; op = 1; end
      P_EXR:    begin a = 1; op = rop(f, f7); end
      P_EXI:    begin a = 1; b = 2'b10; op = 1; end
      P_MEMRD:  mr = 1;
      P_MEMWR:  mw = 1;
      P_WBA:    rg = 1;
      P_WBM:    begin rg = 1; m2r = 1; end
      P_BR:     begin a = 1; op = 2; ps = 1; pw = (f == 3'b000) ? z : !z; end
      default:  ill = 1;
    endcase
    return {rw, pw, ps, iw, mr, mw, rg, m2r, a, b, 4'(op), ill};
  endfunction

  // Cycle-by-cycle phase list of one instruction, starting at its first fetch cycle
  task automatic build(input int w, input logic [6:0] o, input logic [2:0] f, input logic f7,
                       output int ph [32], output int n);
    n = 0;
    for (int i = 0; i < 32; i++) ph[i] = P_TRAP;
    for (int i = 0; i < w; i++) begin ph[n] = P_FETCH; n++; end
    ph[n] = P_FLAST; n++;
    ph[n] = P_DECODE; n++;
    if (o == OPC_R && rop(f, f7) > 0) begin
      ph[n] = P_EXR; n++; ph[n] = P_WBA; n++;
    end else if (o == OPC_I && f == 3'b000) begin
      ph[n] = P_EXI; n++; ph[n] = P_WBA; n++;
    end else if (o == OPC_LD && f == 3'b011) begin
      ph[n] = P_EXI; n++;
      for (int i = 0; i <= w; i++) begin ph[n] = P_MEMRD; n++; end
      ph[n] = P_WBM; n++;
    end else if (o == OPC_SD && f == 3'b011) begin
      ph[n] = P_EXI; n++;
      for (int i = 0; i <= w; i++) begin ph[n] = P_MEMWR; n++; end
    end else if (o == OPC_BR && f <= 3'b001) begin
      ph[n] = P_BR; n++;
    end else begin
      for (int i = 0; i < 20; i++) begin ph[n] = P_TRAP; n++; end
    end
  endtask

  task automatic chk(input string nm, input int k, input logic [15:0] a, input logic [15:0] e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t actual=%h required=%h", nm, k, $time, a, e);
    end
  endtask

  task automatic chk_int(input string nm, input int k, input int a, input int e);
    n_cmp++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t actual=%0d required=%0d", nm, k, $time, a, e);
    end
  endtask

  task automatic reset_seq(input int k, input bit already_low);
    logic [15:0] rv;
    rv = exp_vec(P_RESET, 3'b000, 1'b0, 1'b0);
    if (!already_low) begin
      rst_n[k] = 1'b0;
      #1;
      chk("rst_async", k, act[k], rv);
    end
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold", k, act[k], rv);
    end
    rst_n[k] = 1'b1;
    repeat (rcyc(k)) begin
      @(negedge clk);
      chk("rst_post", k, act[k], rv);
    end
  endtask

  // zsel: -1 drives a random zero flag every cycle, otherwise holds it at zsel
  task automatic run_instr(input int k, input logic [6:0] o, input logic [2:0] f, input logic f7,
                           input int zsel, input int abort_at,
                           output int len, output int n_mr, output int n_mw, output int n_rg,
                           output int n_pw, output bit trapped);
    int ph [32];
    int n;
    len = 0; n_mr = 0; n_mw = 0; n_rg = 0; n_pw = 0; trapped = 0;
    build(wpar(k), o, f, f7, ph, n);
    len = n;
    trapped = (ph[n-1] == P_TRAP);
    opc[k] = o; f3[k] = f; f75[k] = f7;
    zr[k] = (zsel < 0) ? 1'($urandom) : 1'(zsel);
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        @(posedge clk);
        #2;
        chk("abort_pre", k, act[k], exp_vec(ph[i], f, f7, zr[k]));
        rst_n[k] = 1'b0;
        #1;
        chk("abort_rst", k, act[k], exp_vec(P_RESET, 3'b000, 1'b0, 1'b0));
        return;
      end
      @(negedge clk);
      chk(pname(ph[i]), k, act[k], exp_vec(ph[i], f, f7, zr[k]));
      n_mr += int'(act[k][11]);
      n_mw += int'(act[k][10]);
      n_rg += int'(act[k][9]);
      n_pw += int'(act[k][14]);
      zr[k] = (zsel < 0) ? 1'($urandom) : 1'(zsel);
    end
  endtask

  task automatic run(input int k);
    int len, mr, mw, rg, pw, sel;
    bit tr;
    logic [6:0] o;
    logic [2:0] f;
    rst_n[k] = 1'b1; opc[k] = '0; f3[k] = '0; f75[k] = 1'b0; zr[k] = 1'b0;
    #2;
    reset_seq(k, 1'b0);
    if (k == 0) begin
      run_instr(0, OPC_R, 3'b000, 1'b0, -1, -1, len, mr, mw, rg, pw, tr);
      chk_int("add_len", 0, len, 4);
      chk_int("add_regwrite_cycles", 0, rg, 1);
      run_instr(0, OPC_R, 3'b000, 1'b1, -1, -1, len, mr, mw, rg, pw, tr);
      chk_int("sub_len", 0, len, 4);
      run_instr(0, OPC_BR, 3'b000, 1'b0, 1, -1, len, mr, mw, rg, pw, tr);
      chk_int("beq_taken_pcwrites", 0, pw, 2);
      chk_int("beq_len", 0, len, 3);
      run_instr(0, OPC_BR, 3'b000, 1'b0, 0, -1, len, mr, mw, rg, pw, tr);
      chk_int("beq_not_taken_pcwrites", 0, pw, 1);
      run_instr(0, OPC_BR, 3'b001, 1'b0, 1, -1, len, mr, mw, rg, pw, tr);
      chk_int("bne_not_taken_pcwrites", 0, pw, 1);
      run_instr(0, OPC_BR, 3'b001, 1'b0, 0, -1, len, mr, mw, rg, pw, tr);
      chk_int("bne_taken_pcwrites", 0, pw, 2);
      run_instr(0, OPC_LD, 3'b011, 1'b0, -1, -1, len, mr, mw, rg, pw, tr);
      chk_int("ld_w0_len", 0, len, 5);
    end else begin
      run_instr(1, OPC_LD, 3'b011, 1'b0, -1, -1, len, mr, mw, rg, pw, tr);
      chk_int("ld_len", 1, len, 9);
      chk_int("ld_memread_cycles", 1, mr, 6);
      chk_int("ld_regwrite_cycles", 1, rg, 1);
      run_instr(1, OPC_SD, 3'b011, 1'b0, -1, -1, len, mr, mw, rg, pw, tr);
      chk_int("sd_len", 1, len, 8);
      chk_int("sd_memwrite_cycles", 1, mw, 3);
      run_instr(1, 7'b1111111, 3'b000, 1'b0, -1, -1, len, mr, mw, rg, pw, tr);
      chk_int("trap_opcode_flag", 1, int'(tr), 1);
      reset_seq(1, 1'b0);
      run_instr(1, OPC_R, 3'b001, 1'b0, -1, -1, len, mr, mw, rg, pw, tr);
      chk_int("trap_rfunct_flag", 1, int'(tr), 1);
      reset_seq(1, 1'b0);
      run_instr(1, OPC_SD, 3'b011, 1'b0, -1, 6, len, mr, mw, rg, pw, tr);
      reset_seq(1, 1'b1);
    end
    for (int t = 0; t < 120; t++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: o = OPC_R;  1: o = OPC_I;  2: o = OPC_LD;
        3: o = OPC_SD; 4: o = OPC_BR; default: o = 7'($urandom);
      endcase
      case (sel)
        0: f = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(4, 7));
        1: f = 3'b000;
        2, 3: f = 3'b011;
        4: f = 3'($urandom_range(0, 1));
        default: f = 3'($urandom);
      endcase
      if ($urandom_range(0, 5) == 0) f = 3'($urandom);
      run_instr(k, o, f, 1'($urandom), -1, -1, len, mr, mw, rg, pw, tr);
      if (tr) reset_seq(k, 1'b0);
    end
  endtask

  initial begin
    fork
      run(0);
      run(1);
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
